// File: rtl/bf_decoder.sv
// rtl/bf_decoder.sv - serial bit-flipping decoder recovering e0/e1 from syndrome s
module bf_decoder #(
  parameter int R        = 127,
  parameter int W        = 5,
  parameter int POS_W    = 8,
  parameter int THRESH   = 3,
  parameter int MAX_ITER = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [R-1:0]         s,
  input  logic [W*POS_W-1:0]   h0_pos_flat,
  input  logic [W*POS_W-1:0]   h1_pos_flat,
  output logic [R-1:0]         e0,
  output logic [R-1:0]         e1,
  output logic [R-1:0]         s_res,
  output logic                 busy,
  output logic                 done,
  output logic                 success
);

  localparam int JW    = $clog2(R);
  localparam int IW    = (MAX_ITER > 0) ? $clog2(MAX_ITER + 1) : 1;
  localparam int UPC_W = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     iter;
  logic [JW-1:0]     j;
  logic              blk;

  logic [POS_W-1:0]  idx [W];
  logic [UPC_W-1:0]  upc;
  logic              flip;
  logic [R-1:0]      flip_mask;
  logic              last_bit;
  logic              res_zero;
  logic              iter_max;

  assign last_bit = (j == JW'(R - 1));
  assign res_zero = (s_res == '0);
  assign iter_max = (iter == IW'(MAX_ITER));

  assign busy = (state == CHECK) || (state == SCAN);
  assign done = (state == DONE);

  // Tap indices for the current bit, unsatisfied-parity count and the syndrome toggle mask.
  always_comb begin
    logic [POS_W:0]   sum;
    logic [POS_W-1:0] pos;
    upc       = '0;
    flip_mask = '0;
    sum       = '0;
    pos       = '0;
    for (int k = 0; k < W; k++) begin
      pos = blk ? h1_pos_flat[k*POS_W +: POS_W] : h0_pos_flat[k*POS_W +: POS_W];
      sum = {1'b0, POS_W'(j)} + {1'b0, pos};
      if (sum >= (POS_W+1)'(R)) begin
        sum = sum - (POS_W+1)'(R);
      end
      idx[k] = sum[POS_W-1:0];
      upc    = upc + UPC_W'(s_res[idx[k]]);
    end
    // Duplicate taps toggle the same bit twice and so cancel out.
    for (int k = 0; k < W; k++) begin
      flip_mask[idx[k]] = ~flip_mask[idx[k]];
    end
    flip = (upc >= UPC_W'(THRESH));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the exit test only happens in CHECK so a pass always completes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CHECK;
      CHECK: state_nxt = (res_zero || iter_max) ? DONE : SCAN;
      SCAN:  if (blk && last_bit) state_nxt = CHECK;
      DONE:  state_nxt = start ? CHECK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on start, in-place flips during SCAN, result flag in CHECK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e0      <= '0;
      e1      <= '0;
      s_res   <= '0;
      iter    <= '0;
      j       <= '0;
      blk     <= 1'b0;
      success <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            s_res   <= s;
            e0      <= '0;
            e1      <= '0;
            iter    <= '0;
            success <= 1'b0;
          end
        end
        CHECK: begin
          if (res_zero) begin
            success <= 1'b1;
          end else if (iter_max) begin
            success <= 1'b0;
          end else begin
            blk <= 1'b0;
            j   <= '0;
          end
        end
        SCAN: begin
          if (flip) begin
            s_res <= s_res ^ flip_mask;
            if (blk) e1[j] <= ~e1[j];
            else     e0[j] <= ~e0[j];
          end
          if (last_bit) begin
            j <= '0;
            if (blk) begin
              iter <= iter + 1'b1;
              blk  <= 1'b0;
            end else begin
              blk <= 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_decoder.sv
// tb/tb_bf_decoder.sv - self-checking bench for bf_decoder
module tb_bf_decoder;
  localparam int R        = 127;
  localparam int W        = 5;
  localparam int POS_W    = 8;
  localparam int THRESH   = 3;
  localparam int MAX_ITER = 8;
  localparam int PASS_CYC = 2 * R + 1;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [R-1:0]       s;
  logic [W*POS_W-1:0] h0_pos_flat;
  logic [W*POS_W-1:0] h1_pos_flat;
  logic [R-1:0]       e0;
  logic [R-1:0]       e1;
  logic [R-1:0]       s_res;
  logic               busy;
  logic               done;
  logic               success;

  int tests;
  int fails;

  int h [2][W];

  bf_decoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s(s),
    .h0_pos_flat(h0_pos_flat), .h1_pos_flat(h1_pos_flat),
    .e0(e0), .e1(e1), .s_res(s_res),
    .busy(busy), .done(done), .success(success)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [R-1:0] act, input logic [R-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference decoder written straight from the bit-flipping rules with modular arithmetic.
  task automatic model(input logic [R-1:0] sv, output logic [R-1:0] me0, output logic [R-1:0] me1,
                       output logic [R-1:0] mres, output logic msucc, output int passes);
    logic [R-1:0] e [2];
    int cnt;
    mres   = sv;
    e[0]   = '0;
    e[1]   = '0;
    passes = 0;
    msucc  = 1'b0;
    while (1) begin
      if (mres == '0) begin msucc = 1'b1; break; end
      if (passes == MAX_ITER) begin msucc = 1'b0; break; end
      for (int b = 0; b < 2; b++) begin
        for (int jj = 0; jj < R; jj++) begin
          cnt = 0;
          for (int k = 0; k < W; k++) cnt += int'(mres[(jj + h[b][k]) % R]);
          if (cnt >= THRESH) begin
            for (int k = 0; k < W; k++) mres[(jj + h[b][k]) % R] = ~mres[(jj + h[b][k]) % R];
            e[b][jj] = ~e[b][jj];
          end
        end
      end
      passes++;
    end
    me0 = e[0];
    me1 = e[1];
  endtask

  function automatic logic [R-1:0] bits(input int b0, input int b1, input int b2, input int b3, input int b4);
    logic [R-1:0] v;
    v = '0;
    v[b0] = 1'b1; v[b1] = 1'b1; v[b2] = 1'b1; v[b3] = 1'b1; v[b4] = 1'b1;
    return v;
  endfunction

  task automatic launch(input logic [R-1:0] sv);
    @(negedge clk);
    s     = sv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follows a decode edge by edge after its start edge; optional re-start, reset or chained start.
  task automatic run(input string name, input logic [R-1:0] sv, input int restart_edge,
                     input int reset_edge, input bit chain, input logic [R-1:0] chain_s);
    logic [R-1:0] me0, me1, mres;
    logic         msucc;
    int           passes, exp_edge;
    bit           seen;
    model(sv, me0, me1, mres, msucc, passes);
    exp_edge = 1 + passes * PASS_CYC;
    seen     = 1'b0;
    for (int cyc = 1; cyc <= exp_edge; cyc++) begin
      if (cyc == restart_edge) begin start = 1'b1; s = chain_s; end
      if (cyc == reset_edge) rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (cyc == reset_edge) begin
        chk({name, "_rst_busy"}, R'(busy), '0);
        chk({name, "_rst_done"}, R'(done), '0);
        chk({name, "_rst_succ"}, R'(success), '0);
        chk({name, "_rst_e0"}, e0, '0);
        chk({name, "_rst_e1"}, e1, '0);
        chk({name, "_rst_sres"}, s_res, '0);
        rst_n = 1'b1;
        for (int q = 0; q < 3; q++) begin
          @(negedge clk);
          chk({name, "_post_rst_done"}, R'({busy, done}), '0);
        end
        return;
      end
      if (done) begin
        seen = 1'b1;
        chk({name, "_done_edge"}, R'(cyc), R'(exp_edge));
        break;
      end
      if (cyc < exp_edge) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL %s_busy edge=%0d actual=%b required=1", name, cyc, busy);
        end
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout actual=no_done required=done_at_edge_%0d", name, exp_edge);
      return;
    end
    chk({name, "_busy_at_done"}, R'(busy), '0);
    chk({name, "_e0"}, e0, me0);
    chk({name, "_e1"}, e1, me1);
    chk({name, "_sres"}, s_res, mres);
    chk({name, "_success"}, R'(success), R'(msucc));
    if (chain) begin
      s     = chain_s;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end else begin
      @(negedge clk);
      chk({name, "_done_pulse"}, R'(done), '0);
      chk({name, "_success_held"}, R'(success), R'(msucc));
    end
  endtask

  initial begin
    logic [R-1:0] s2, s3, s4, me0, me1, mres;
    logic         msucc;
    int           passes;
    tests = 0;
    fails = 0;
    h[0] = '{0, 9, 27, 50, 90};
    h[1] = '{3, 15, 44, 70, 101};
    for (int k = 0; k < W; k++) begin
      h0_pos_flat[k*POS_W +: POS_W] = POS_W'(h[0][k]);
      h1_pos_flat[k*POS_W +: POS_W] = POS_W'(h[1][k]);
    end
    s2 = bits(7, 16, 34, 57, 97);
    s3 = bits(17, 43, 74, 103, 115);
    s4 = '0;
    s4[0] = 1'b1;
    s     = '0;
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", R'(busy), '0);
    chk("reset_done", R'(done), '0);
    chk("reset_success", R'(success), '0);
    chk("reset_e0", e0, '0);
    chk("reset_e1", e1, '0);
    chk("reset_sres", s_res, '0);
    rst_n = 1'b1;

    // Hand-derived results pin the reference model.
    model(s2, me0, me1, mres, msucc, passes);
    chk("model_t2_e0", me0, R'(1) << 7);
    chk("model_t2_passes", R'(passes), R'(1));
    model(s3, me0, me1, mres, msucc, passes);
    chk("model_t3_e1", me1, R'(1) << 100);
    chk("model_t3_e0", me0, '0);
    model(s4, me0, me1, mres, msucc, passes);
    chk("model_t4_passes", R'(passes), R'(MAX_ITER));
    chk("model_t4_sres", mres, s4);
    chk("model_t4_succ", R'(msucc), '0);

    launch('0);
    run("t1_zero", '0, -1, -1, 1'b0, '0);
    chk("t1_success_lit", R'(success), R'(1));

    launch(s2);
    run("t2_e0_7", s2, -1, -1, 1'b0, '0);
    chk("t2_e0_lit", e0, R'(1) << 7);
    chk("t2_sres_lit", s_res, '0);

    launch(s3);
    run("t3_e1_100", s3, -1, -1, 1'b0, '0);
    chk("t3_e1_lit", e1, R'(1) << 100);

    launch(s4);
    run("t4_nofix", s4, -1, -1, 1'b0, '0);
    chk("t4_sres_lit", s_res, s4);
    chk("t4_success_lit", R'(success), '0);

    launch(s2);
    run("t5_restart_ignored", s2, 100, -1, 1'b0, s3);

    launch(s2);
    run("t5_reset_mid", s2, -1, 150, 1'b0, '0);

    launch(s2);
    run("t6_first", s2, -1, -1, 1'b1, s3);
    run("t6_chained", s3, -1, -1, 1'b0, '0);
    chk("t6_e0_cleared", e0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
